// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - configurable UART receiver (5-8 data bits, parity, 1/2 stop) with RX FIFO
module uart_rx_cfg #(
   parameter int CLK_CNT_W  = 16,
   parameter int FIFO_DEPTH = 4,
   parameter int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                 i_Clock,
   input  logic                 rst_ni,
   input  logic                 i_Rx_Serial,
   input  logic [CLK_CNT_W-1:0] i_Clks_Per_Bit,
   input  logic [1:0]           i_Data_Bits,
   input  logic                 i_Parity_En,
   input  logic                 i_Parity_Odd,
   input  logic                 i_Two_Stop,
   output logic                 o_Rx_Valid,
   input  logic                 i_Rx_Ready,
   output logic [7:0]           o_Rx_Byte,
   output logic                 o_Rx_Par_Err,
   output logic                 o_Rx_Frm_Err,
   output logic                 o_Overrun,
   output logic                 o_Busy,
   output logic [LVL_W-1:0]     o_Fifo_Level
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;

   logic sync1, sync2;

   always_ff @(posedge i_Clock or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
      end else begin
         sync1 <= i_Rx_Serial;
         sync2 <= sync1;
      end
   end

   state_t               state;
   logic [CLK_CNT_W-1:0] cnt, cpb, cpb_m1;
   logic [1:0]           bits_cfg;
   logic                 par_en, par_odd, two_stop;
   logic [2:0]           bit_idx;
   logic                 stop_idx;
   logic [7:0]           shreg;
   logic                 par_err, frm_err, busy;
   logic                 bit_end, half_end, last_data, last_stop, push, push_frm;

   assign cpb_m1    = cpb - CLK_CNT_W'(1);
   assign bit_end   = (cnt == cpb_m1);
   assign half_end  = (cnt == (cpb_m1 >> 1));
   assign last_data = (bit_idx == (3'd4 + {1'b0, bits_cfg}));
   assign last_stop = !two_stop || stop_idx;
   assign push      = (state == S_STOP) && bit_end && last_stop;
   // Frame error accumulates over both stop bits; the push needs the current sample folded in.
   assign push_frm  = frm_err | ~sync2;

   always_ff @(posedge i_Clock or negedge rst_ni) begin
      if (!rst_ni) begin
         state    <= S_IDLE;
         cnt      <= '0;
         cpb      <= '0;
         bits_cfg <= '0;
         par_en   <= 1'b0;
         par_odd  <= 1'b0;
         two_stop <= 1'b0;
         bit_idx  <= '0;
         stop_idx <= 1'b0;
         shreg    <= '0;
         par_err  <= 1'b0;
         frm_err  <= 1'b0;
         busy     <= 1'b0;
      end else begin
         cnt <= cnt + CLK_CNT_W'(1);
         case (state)
            S_IDLE: begin
               cnt <= '0;
               if (!sync2) begin
                  state    <= S_START;
                  busy     <= 1'b1;
                  cpb      <= i_Clks_Per_Bit;
                  bits_cfg <= i_Data_Bits;
                  par_en   <= i_Parity_En;
                  par_odd  <= i_Parity_Odd;
                  two_stop <= i_Two_Stop;
                  bit_idx  <= '0;
                  stop_idx <= 1'b0;
                  shreg    <= '0;
                  par_err  <= 1'b0;
                  frm_err  <= 1'b0;
               end
            end
            S_START: begin
               if (half_end) begin
                  cnt <= '0;
                  if (sync2) begin
                     state <= S_IDLE;
                     busy  <= 1'b0;
                  end else begin
                     state <= S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (bit_end) begin
                  cnt            <= '0;
                  shreg[bit_idx] <= sync2;
                  bit_idx        <= bit_idx + 3'd1;
                  if (last_data) state <= par_en ? S_PARITY : S_STOP;
               end
            end
            S_PARITY: begin
               if (bit_end) begin
                  cnt     <= '0;
                  par_err <= ^shreg ^ sync2 ^ par_odd;
                  state   <= S_STOP;
               end
            end
            S_STOP: begin
               if (bit_end) begin
                  cnt     <= '0;
                  frm_err <= push_frm;
                  if (last_stop) begin
                     if (sync2) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                     end else begin
                        state <= S_BREAK;
                     end
                  end else begin
                     stop_idx <= 1'b1;
                  end
               end
            end
            S_BREAK: begin
               cnt <= '0;
               if (sync2) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   logic [9:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [LVL_W-1:0] level;
   logic             overrun, full, pop, wr_en;
   logic [9:0]       head;

   assign full  = (level == LVL_W'(FIFO_DEPTH));
   assign pop   = (level != '0) && i_Rx_Ready;
   assign wr_en = push && (!full || pop);

   always_ff @(posedge i_Clock) begin
      if (wr_en) mem[wr_ptr] <= {shreg, par_err, push_frm};
   end

   always_ff @(posedge i_Clock or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level   <= '0;
         overrun <= 1'b0;
      end else begin
         overrun <= push && full && !pop;
         if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
         case ({wr_en, pop})
            2'b10:   level <= level + LVL_W'(1);
            2'b01:   level <= level - LVL_W'(1);
            default: level <= level;
         endcase
      end
   end

   assign o_Rx_Valid   = (level != '0);
   assign head         = o_Rx_Valid ? mem[rd_ptr] : 10'd0;
   assign o_Rx_Byte    = head[9:2];
   assign o_Rx_Par_Err = head[1];
   assign o_Rx_Frm_Err = head[0];
   assign o_Overrun    = overrun;
   assign o_Busy       = busy;
   assign o_Fifo_Level = level;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb/tb_uart_rx_cfg.sv - directed self-checking bench for uart_rx_cfg
module tb_uart_rx_cfg;

   logic        clk = 1'b0;
   logic        rst_ni = 1'b0;
   logic        rx = 1'b1;
   logic [15:0] cpb = 16'd16;
   logic [1:0]  dbits = 2'b11;
   logic        par_en = 1'b0, par_odd = 1'b0, two_stop = 1'b0;
   logic        rdy = 1'b0;
   logic        valid, perr, ferr, ovr, busy;
   logic [7:0]  rbyte;
   logic [2:0]  level;

   int total = 0;
   int bad = 0;
   int ovr_cnt = 0;

   uart_rx_cfg dut (
      .i_Clock(clk), .rst_ni(rst_ni), .i_Rx_Serial(rx), .i_Clks_Per_Bit(cpb),
      .i_Data_Bits(dbits), .i_Parity_En(par_en), .i_Parity_Odd(par_odd), .i_Two_Stop(two_stop),
      .o_Rx_Valid(valid), .i_Rx_Ready(rdy), .o_Rx_Byte(rbyte), .o_Rx_Par_Err(perr),
      .o_Rx_Frm_Err(ferr), .o_Overrun(ovr), .o_Busy(busy), .o_Fifo_Level(level)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (ovr === 1'b1) ovr_cnt++;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // Drives one frame at 16 clocks per bit, starting at the current negedge.
   task automatic send_frame(input logic [7:0] d, input int nbits, input bit pe, input bit pbit,
                             input int nstop, input bit last_stop, input int ready_at, input int rst_at);
      logic [11:0] seq;
      int len;
      seq = '1;
      seq[0] = 1'b0;
      for (int i = 0; i < nbits; i++) seq[1+i] = d[i];
      len = 1 + nbits;
      if (pe) begin
         seq[len] = pbit;
         len++;
      end
      seq[len] = (nstop == 1) ? last_stop : 1'b1;
      len++;
      if (nstop == 2) begin
         seq[len] = last_stop;
         len++;
      end
      for (int c = 0; c < len * 16; c++) begin
         if (c == rst_at) begin
            rst_ni = 1'b0;
            rx = 1'b1;
            break;
         end
         rx = seq[c/16];
         if (ready_at >= 0) rdy = (c == ready_at);
         @(negedge clk);
      end
   endtask

   task automatic pop();
      rdy = 1'b1;
      @(negedge clk);
      rdy = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      total++;
      if ({valid, rbyte, perr, ferr, ovr, busy, level} !== 16'd0) begin
         bad++;
         $display("FAIL reset_hold: got %h want 0", {valid, rbyte, perr, ferr, ovr, busy, level});
      end
      rst_ni = 1'b1;
      repeat (3) @(negedge clk);
      total++;
      if ({valid, rbyte, perr, ferr, ovr, busy, level} !== 16'd0) begin
         bad++;
         $display("FAIL reset_release: got %h want 0", {valid, rbyte, perr, ferr, ovr, busy, level});
      end
   endtask

   task automatic test_8n1();
      dbits = 2'b11; par_en = 1'b0; two_stop = 1'b0;
      send_frame(8'hA5, 8, 0, 0, 1, 1, -1, -1);
      total++;
      if ({valid, rbyte, perr, ferr} !== {1'b1, 8'hA5, 1'b0, 1'b0}) begin
         bad++;
         $display("FAIL 8n1_head: got %h want %h", {valid, rbyte, perr, ferr}, {1'b1, 8'hA5, 1'b0, 1'b0});
      end
      total++;
      if (level !== 3'd1 || busy !== 1'b0) begin
         bad++;
         $display("FAIL 8n1_level: got level=%0d busy=%b want level=1 busy=0", level, busy);
      end
      pop();
      total++;
      if ({valid, rbyte, perr, ferr, level} !== 14'd0) begin
         bad++;
         $display("FAIL 8n1_after_pop: got %h want 0", {valid, rbyte, perr, ferr, level});
      end
   endtask

   task automatic test_parity();
      dbits = 2'b10; par_en = 1'b1; par_odd = 1'b0;
      send_frame(8'h41, 7, 1, 1, 1, 1, -1, -1);
      total++;
      if ({valid, rbyte, perr, ferr} !== {1'b1, 8'h41, 1'b1, 1'b0}) begin
         bad++;
         $display("FAIL parity_even_err: got %h want %h", {valid, rbyte, perr, ferr}, {1'b1, 8'h41, 1'b1, 1'b0});
      end
      pop();
      par_odd = 1'b1;
      send_frame(8'h41, 7, 1, 1, 1, 1, -1, -1);
      total++;
      if ({valid, rbyte, perr, ferr} !== {1'b1, 8'h41, 1'b0, 1'b0}) begin
         bad++;
         $display("FAIL parity_odd_ok: got %h want %h", {valid, rbyte, perr, ferr}, {1'b1, 8'h41, 1'b0, 1'b0});
      end
      pop();
      dbits = 2'b00; par_en = 1'b0; par_odd = 1'b0;
      send_frame(8'hF3, 5, 0, 0, 1, 1, -1, -1);
      total++;
      if ({valid, rbyte, perr, ferr} !== {1'b1, 8'h13, 1'b0, 1'b0}) begin
         bad++;
         $display("FAIL five_bits: got %h want %h", {valid, rbyte, perr, ferr}, {1'b1, 8'h13, 1'b0, 1'b0});
      end
      pop();
      dbits = 2'b11;
   endtask

   task automatic test_break();
      two_stop = 1'b1;
      send_frame(8'h3C, 8, 0, 0, 2, 0, -1, -1);
      repeat (100) @(negedge clk);
      total++;
      if ({valid, rbyte, perr, ferr} !== {1'b1, 8'h3C, 1'b0, 1'b1}) begin
         bad++;
         $display("FAIL break_frame: got %h want %h", {valid, rbyte, perr, ferr}, {1'b1, 8'h3C, 1'b0, 1'b1});
      end
      total++;
      if (level !== 3'd1 || busy !== 1'b1) begin
         bad++;
         $display("FAIL break_hold: got level=%0d busy=%b want level=1 busy=1", level, busy);
      end
      pop();
      rx = 1'b1;
      repeat (4) @(negedge clk);
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL break_exit: got busy=%b want 0", busy);
      end
      send_frame(8'h55, 8, 0, 0, 2, 1, -1, -1);
      total++;
      if ({valid, rbyte, perr, ferr, level} !== {1'b1, 8'h55, 1'b0, 1'b0, 3'd1}) begin
         bad++;
         $display("FAIL break_next: got %h want %h", {valid, rbyte, perr, ferr, level}, {1'b1, 8'h55, 1'b0, 1'b0, 3'd1});
      end
      pop();
      two_stop = 1'b0;
   endtask

   task automatic test_glitch();
      rx = 1'b0;
      repeat (3) @(negedge clk);
      rx = 1'b1;
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("FAIL glitch_start: got busy=%b want 1", busy);
      end
      repeat (20) @(negedge clk);
      total++;
      if (busy !== 1'b0 || level !== 3'd0 || valid !== 1'b0) begin
         bad++;
         $display("FAIL glitch_abort: got busy=%b level=%0d valid=%b want 0 0 0", busy, level, valid);
      end
   endtask

   task automatic test_back_to_back();
      int o0;
      logic [7:0] exp;
      o0 = ovr_cnt;
      for (int i = 0; i < 5; i++) send_frame(8'(8'h11 * (i + 1)), 8, 0, 0, 1, 1, -1, -1);
      total++;
      if (level !== 3'd4 || (ovr_cnt - o0) !== 1) begin
         bad++;
         $display("FAIL overrun_fill: got level=%0d pulses=%0d want level=4 pulses=1", level, ovr_cnt - o0);
      end
      for (int i = 0; i < 4; i++) begin
         exp = 8'(8'h11 * (i + 1));
         total++;
         if ({valid, rbyte} !== {1'b1, exp}) begin
            bad++;
            $display("FAIL overrun_order[%0d]: got %h want %h", i, {valid, rbyte}, {1'b1, exp});
         end
         pop();
      end
      total++;
      if (level !== 3'd0) begin
         bad++;
         $display("FAIL overrun_drain: got level=%0d want 0", level);
      end
      for (int i = 0; i < 4; i++) send_frame(8'(8'h61 + i), 8, 0, 0, 1, 1, -1, -1);
      o0 = ovr_cnt;
      send_frame(8'h65, 8, 0, 0, 1, 1, 154, -1);
      total++;
      if (level !== 3'd4 || (ovr_cnt - o0) !== 0) begin
         bad++;
         $display("FAIL push_pop_full: got level=%0d pulses=%0d want level=4 pulses=0", level, ovr_cnt - o0);
      end
      for (int i = 0; i < 4; i++) begin
         exp = 8'(8'h62 + i);
         total++;
         if ({valid, rbyte} !== {1'b1, exp}) begin
            bad++;
            $display("FAIL push_pop_order[%0d]: got %h want %h", i, {valid, rbyte}, {1'b1, exp});
         end
         pop();
      end
   endtask

   task automatic test_reset_mid();
      send_frame(8'h77, 8, 0, 0, 1, 1, -1, -1);
      send_frame(8'h99, 8, 0, 0, 1, 1, -1, 64);
      @(negedge clk);
      total++;
      if ({valid, rbyte, perr, ferr, ovr, busy, level} !== 16'd0) begin
         bad++;
         $display("FAIL reset_mid: got %h want 0", {valid, rbyte, perr, ferr, ovr, busy, level});
      end
      rst_ni = 1'b1;
      repeat (3) @(negedge clk);
      total++;
      if ({valid, busy, level} !== 5'd0) begin
         bad++;
         $display("FAIL reset_mid_release: got %h want 0", {valid, busy, level});
      end
      send_frame(8'h12, 8, 0, 0, 1, 1, -1, -1);
      total++;
      if ({valid, rbyte, perr, ferr, level} !== {1'b1, 8'h12, 1'b0, 1'b0, 3'd1}) begin
         bad++;
         $display("FAIL reset_mid_next: got %h want %h", {valid, rbyte, perr, ferr, level}, {1'b1, 8'h12, 1'b0, 1'b0, 3'd1});
      end
      pop();
   endtask

   initial begin
      test_reset();
      test_8n1();
      test_parity();
      test_break();
      test_glitch();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
